// File: rtl/wb_regfile_stage.sv
// Writeback stage: picks the writeback result, commits it to R0-R14, serves
// two decode read ports (R15 reads as PC+8, same-cycle write bypass), drives
// the PC redirect and keeps saturating writeback/branch counters plus a
// sticky flag for register writes aimed at R15 without a PC write.
module wb_regfile_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrcW,
   input  logic              RegWriteW,
   input  logic              MemtoRegW,
   input  logic [3:0]        RdW,
   input  logic [DATA_W-1:0] ALUResultW,
   input  logic [DATA_W-1:0] ReadDataW,
   input  logic [3:0]        RA1D,
   input  logic [3:0]        RA2D,
   input  logic [DATA_W-1:0] PCPlus8D,
   input  logic              CountClr,
   output logic [DATA_W-1:0] RD1D,
   output logic [DATA_W-1:0] RD2D,
   output logic [DATA_W-1:0] ResultW,
   output logic              PCWrEnW,
   output logic [DATA_W-1:0] PCNextW,
   output logic [CNT_W-1:0]  WriteCount,
   output logic [CNT_W-1:0]  BranchCount,
   output logic              R15WrErr
);

   // R0-R14 only; R15 is the PC and lives outside this file
   logic [DATA_W-1:0] rf_reg [0:14];
   logic [CNT_W-1:0]  write_count_reg;
   logic [CNT_W-1:0]  branch_count_reg;
   logic              r15_err_reg;
   logic              commit;
   logic              r15_misuse;

   assign commit     = RegWriteW && (RdW != 4'hF);
   assign r15_misuse = RegWriteW && (RdW == 4'hF) && !PCSrcW;

   // Result select and PC redirect are purely combinational
   always_comb begin
      ResultW = MemtoRegW ? ReadDataW : ALUResultW;
      PCWrEnW = PCSrcW;
      PCNextW = ResultW;
   end

   // One flop row per architectural register; async reset aborts any write
   generate
      for (genvar gi = 0; gi < 15; gi++) begin : g_rf
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               rf_reg[gi] <= '0;
            else if (commit && (RdW == 4'(gi)))
               rf_reg[gi] <= ResultW;
         end
      end
   endgenerate

   // Read priority: PC+8, then bypass of the in-flight write, then stored value.
   // During reset the stored value is 0 and the bypass is suppressed.
   function automatic logic [DATA_W-1:0] read_port(input logic [3:0] ra);
      logic [DATA_W-1:0] v;
      v = '0;
      if (ra == 4'hF)
         v = PCPlus8D;
      else if (reset)
         v = '0;
      else if (commit && (RdW == ra))
         v = ResultW;
      else
         for (int i = 0; i < 15; i++)
            if (ra == 4'(i))
               v = rf_reg[i];
      return v;
   endfunction

   // Two independent decode read ports
   always_comb begin
      RD1D = read_port(RA1D);
      RD2D = read_port(RA2D);
   end

   // Saturating counters and sticky error flag; clear beats increment/set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_count_reg  <= '0;
         branch_count_reg <= '0;
         r15_err_reg      <= 1'b0;
      end else if (CountClr) begin
         write_count_reg  <= '0;
         branch_count_reg <= '0;
         r15_err_reg      <= 1'b0;
      end else begin
         if (commit && (write_count_reg != '1))
            write_count_reg <= write_count_reg + 1'b1;
         if (PCSrcW && (branch_count_reg != '1))
            branch_count_reg <= branch_count_reg + 1'b1;
         if (r15_misuse)
            r15_err_reg <= 1'b1;
      end
   end

   assign WriteCount  = write_count_reg;
   assign BranchCount = branch_count_reg;
   assign R15WrErr    = r15_err_reg;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
// A second instance with CNT_W=4 shares the inputs to exercise saturation.
module tb_wb_regfile_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrcW, RegWriteW, MemtoRegW, CountClr;
   logic [3:0]  RdW, RA1D, RA2D;
   logic [31:0] ALUResultW, ReadDataW, PCPlus8D;

   logic [31:0] RD1D, RD2D, ResultW, PCNextW, WriteCount, BranchCount;
   logic        PCWrEnW, R15WrErr;

   logic [31:0] RD1D_4, RD2D_4, ResultW_4, PCNextW_4;
   logic [3:0]  WriteCount_4, BranchCount_4;
   logic        PCWrEnW_4, R15WrErr_4;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   wb_regfile_stage #(.DATA_W(32), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
      .MemtoRegW(MemtoRegW), .RdW(RdW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .RA1D(RA1D), .RA2D(RA2D), .PCPlus8D(PCPlus8D),
      .CountClr(CountClr), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
      .PCWrEnW(PCWrEnW), .PCNextW(PCNextW), .WriteCount(WriteCount),
      .BranchCount(BranchCount), .R15WrErr(R15WrErr)
   );

   wb_regfile_stage #(.DATA_W(32), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
      .MemtoRegW(MemtoRegW), .RdW(RdW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .RA1D(RA1D), .RA2D(RA2D), .PCPlus8D(PCPlus8D),
      .CountClr(CountClr), .RD1D(RD1D_4), .RD2D(RD2D_4), .ResultW(ResultW_4),
      .PCWrEnW(PCWrEnW_4), .PCNextW(PCNextW_4), .WriteCount(WriteCount_4),
      .BranchCount(BranchCount_4), .R15WrErr(R15WrErr_4)
   );

   localparam int S_RD1 = 0, S_RD2 = 1, S_RES = 2, S_PCWE = 3, S_PCN = 4,
                  S_WC = 5, S_BC = 6, S_ERR = 7, S_WC4 = 8, S_BC4 = 9, S_ERR4 = 10;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   task automatic expect_val(input int sel, input logic [31:0] v, input string name);
      exp_t e;
      e.sel = sel; e.exp = v; e.name = name;
      sb_q.push_back(e);
   endtask

   function automatic logic [31:0] get_act(input int sel);
      case (sel)
         S_RD1:  return RD1D;
         S_RD2:  return RD2D;
         S_RES:  return ResultW;
         S_PCWE: return {31'd0, PCWrEnW};
         S_PCN:  return PCNextW;
         S_WC:   return WriteCount;
         S_BC:   return BranchCount;
         S_ERR:  return {31'd0, R15WrErr};
         S_WC4:  return {28'd0, WriteCount_4};
         S_BC4:  return {28'd0, BranchCount_4};
         S_ERR4: return {31'd0, R15WrErr_4};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: compare every queued expectation on the falling edge
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb_q.pop_front();
         act = get_act(e.sel);
         tests_run++;
         if (act !== e.exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      PCSrcW = 0; RegWriteW = 0; MemtoRegW = 0; CountClr = 0;
      RdW = 0; ALUResultW = 0; ReadDataW = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1;
      idle_inputs();
      RA1D = 4'd3; RA2D = 4'd15; PCPlus8D = 32'h108;

      // Values seen while reset is held
      next_cycle();
      expect_val(S_RD1, 32'h0,   "rst_rd1_r3");
      expect_val(S_RD2, 32'h108, "rst_rd2_r15");
      next_cycle();
      reset = 0;
      $display("[TB] reset released");

      // 1: reset state
      expect_val(S_RD1, 32'h0,   "t1_rd1_r3");
      expect_val(S_RD2, 32'h108, "t1_rd2_pc8");
      expect_val(S_WC,  32'h0,   "t1_wcount");
      expect_val(S_BC,  32'h0,   "t1_bcount");
      expect_val(S_ERR, 32'h0,   "t1_err");

      // 2: load writeback to R5 with bypass on both ports
      next_cycle();
      RegWriteW = 1; RdW = 5; MemtoRegW = 1; ReadDataW = 32'hDEADBEEF;
      ALUResultW = 32'h1234; RA1D = 5; RA2D = 5;
      $display("[TB] write R5=DEADBEEF (load path)");
      expect_val(S_RES, 32'hDEADBEEF, "t2_result_mem");
      expect_val(S_RD1, 32'hDEADBEEF, "t2_bypass_rd1");
      expect_val(S_RD2, 32'hDEADBEEF, "t2_bypass_rd2");
      next_cycle();
      idle_inputs();
      ALUResultW = 32'h0000_00AA;
      RA1D = 5; RA2D = 6;
      $display("[TB] read back R5");
      expect_val(S_RD1, 32'hDEADBEEF, "t2_rd1_after");
      expect_val(S_RD2, 32'h0,        "t2_rd2_r6");
      expect_val(S_RES, 32'h0000_00AA, "t2_result_alu");
      expect_val(S_WC,  32'd1,        "t2_wcount");

      // 3: branch via write to R15
      next_cycle();
      PCSrcW = 1; RegWriteW = 1; RdW = 15; MemtoRegW = 0; ALUResultW = 32'h200;
      RA1D = 5; RA2D = 15; PCPlus8D = 32'h310;
      $display("[TB] branch to 0x200");
      expect_val(S_PCWE, 32'd1,   "t3_pcwren");
      expect_val(S_PCN,  32'h200, "t3_pcnext");
      expect_val(S_RD2,  32'h310, "t3_rd2_pc8_not_bypassed");
      next_cycle();
      idle_inputs();
      $display("[TB] after branch");
      expect_val(S_PCWE, 32'd0,        "t3_pcwren_low");
      expect_val(S_BC,   32'd1,        "t3_bcount");
      expect_val(S_WC,   32'd1,        "t3_wcount_same");
      expect_val(S_ERR,  32'd0,        "t3_err_clear");
      expect_val(S_RD1,  32'hDEADBEEF, "t3_rf_untouched");

      // 4: register write to R15 without PC write sets the sticky flag
      next_cycle();
      RegWriteW = 1; RdW = 15; ALUResultW = 32'h444;
      $display("[TB] illegal R15 write");
      next_cycle();
      idle_inputs();
      expect_val(S_ERR, 32'd1, "t4_err_set");
      expect_val(S_WC,  32'd1, "t4_wcount_no_commit");
      next_cycle();
      expect_val(S_ERR, 32'd1, "t4_err_sticky");
      next_cycle();
      CountClr = 1; RegWriteW = 1; RdW = 2; ALUResultW = 32'hA5A5;
      $display("[TB] clear with concurrent write R2=A5A5");
      next_cycle();
      idle_inputs();
      RA1D = 2; RA2D = 5;
      expect_val(S_ERR, 32'd0,      "t4_err_cleared");
      expect_val(S_WC,  32'd0,      "t4_wcount_cleared");
      expect_val(S_BC,  32'd0,      "t4_bcount_cleared");
      expect_val(S_RD1, 32'hA5A5,   "t4_rf_commit_kept");
      expect_val(S_RD2, 32'hDEADBEEF, "t4_rf_r5_kept");

      // 5: 20 commits; the 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         RegWriteW = 1; RdW = 3; MemtoRegW = 0; ALUResultW = 32'h100 + i;
         RA1D = 3; RA2D = 5;
         if (i == 0)
            $display("[TB] 20 commits to R3");
         expect_val(S_RD1, 32'h100 + i, "t5_bypass_r3");
         expect_val(S_RD2, 32'hDEADBEEF, "t5_rd2_r5");
         if (i == 16)
            expect_val(S_WC4, 32'd15, "t5_wc4_at16");
      end
      next_cycle();
      idle_inputs();
      $display("[TB] commit counts");
      expect_val(S_WC4, 32'd15,    "t5_wc4_saturated");
      expect_val(S_WC,  32'd20,    "t5_wc32");
      expect_val(S_RD1, 32'h113,   "t5_r3_last");

      // 6: reset in the middle of a write to R7
      next_cycle();
      RegWriteW = 1; RdW = 7; ALUResultW = 32'h55;
      $display("[TB] write R7=55");
      next_cycle();
      idle_inputs();
      RA1D = 7; RA2D = 5;
      expect_val(S_RD1, 32'h55, "t6_r7_written");
      next_cycle();
      RegWriteW = 1; RdW = 7; ALUResultW = 32'h77;
      #2;
      reset = 1;
      $display("[TB] reset during write to R7");
      expect_val(S_RD1, 32'h0, "t6_rd1_in_reset");
      expect_val(S_WC,  32'h0, "t6_wc_in_reset");
      next_cycle();
      idle_inputs();
      reset = 0;
      expect_val(S_RD1,  32'h0, "t6_r7_after_reset");
      expect_val(S_RD2,  32'h0, "t6_r5_after_reset");
      expect_val(S_WC,   32'h0, "t6_wcount");
      expect_val(S_BC,   32'h0, "t6_bcount");
      expect_val(S_ERR,  32'h0, "t6_err");
      expect_val(S_WC4,  32'h0, "t6_wc4");
      expect_val(S_BC4,  32'h0, "t6_bc4");
      expect_val(S_ERR4, 32'h0, "t6_err4");

      next_cycle();
      next_cycle();
      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
